// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the handshaked data-memory responder.
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage with byte-lane writes and a registered read/response port.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              clr,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (acc && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // rdata doubles as the response data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (acc) begin
      rdata <= we ? '0 : mem[idx];
    end else if (clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory target: req/rsp handshakes, wait states, error decode.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);

  state_e            state;
  state_e            state_nx;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err;
  logic              accept;
  logic              fire;
  logic              done;
  logic              acc;
  logic              clr;

  assign err = (addr_q[1:0] != 2'b00) ||
               ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          fire     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // errored requests never strobe the array, only clear its data reg
  assign acc = fire && !err;
  assign clr = (fire && err) || done;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= WAIT_LD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (fire) begin
        rsp_err <= err;
      end else if (done) begin
        rsp_err <= 1'b0;
      end
    end
  end

  dmem_responder_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .acc   (acc),
    .clr   (clr),
    .we    (we_q),
    .idx   (addr_q[IW+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (rsp_rdata)
  );

endmodule
